// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - bus target serving RAM, output port, timer and reset vector
module bus_responder #(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] RESET_VEC   = 16'h0200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        busy,
    output logic [7:0]  port_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] cap_addr;
    logic        cap_rw;
    logic [7:0]  cap_wdata;
    logic [15:0] timer;
    logic [7:0]  snapshot;
    logic [7:0]  snap_pend;
    logic [7:0]  mem [0:(1 << RAM_AW) - 1];

    logic [15:0] lk_addr;
    logic [7:0]  read_value;
    logic        ram_hit;

    // With zero wait states capture and RESP entry share an edge, so the
    // read lookup must see the live bus address while still in IDLE.
    assign lk_addr = (state == S_IDLE) ? addr : cap_addr;
    assign ram_hit = (cap_addr[15:RAM_AW] == '0);

    // Address decode for reads; I/O locations win over RAM
    always_comb begin
        read_value = 8'hFF;
        if (lk_addr == 16'hFF00)
            read_value = port_out;
        else if (lk_addr == 16'hFF01)
            read_value = timer[7:0];
        else if (lk_addr == 16'hFF02)
            read_value = snapshot;
        else if (lk_addr == 16'hFFFC)
            read_value = RESET_VEC[7:0];
        else if (lk_addr == 16'hFFFD)
            read_value = RESET_VEC[15:8];
        else if (lk_addr[15:RAM_AW] == '0)
            read_value = mem[lk_addr[RAM_AW-1:0]];
    end

    // Bus FSM, timer and all register side effects
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_addr  <= 16'h0000;
            cap_rw    <= 1'b0;
            cap_wdata <= 8'h00;
            timer     <= 16'h0000;
            snapshot  <= 8'h00;
            snap_pend <= 8'h00;
            port_out  <= 8'h00;
            rdata     <= 8'h00;
            ack       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            timer <= timer + 16'd1;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cap_addr  <= addr;
                        cap_rw    <= rw;
                        cap_wdata <= wdata;
                        busy      <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state     <= S_RESP;
                            ack       <= 1'b1;
                            snap_pend <= timer[15:8];
                            if (rw)
                                rdata <= read_value;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WS_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        ack       <= 1'b1;
                        snap_pend <= timer[15:8];
                        if (cap_rw)
                            rdata <= read_value;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    if (cap_rw) begin
                        if (cap_addr == 16'hFF01)
                            snapshot <= snap_pend;
                    end else begin
                        if (cap_addr == 16'hFF00)
                            port_out <= cap_wdata;
                        if (cap_addr == 16'hFF01)
                            timer <= 16'h0000;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM write commits on the edge that ends RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && state == S_RESP && !cap_rw && ram_hit)
            mem[cap_addr[RAM_AW-1:0]] <= cap_wdata;
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        sel = 1'b0;

    logic [7:0]  rdata_a, rdata_b, port_a, port_b;
    logic        ack_a, ack_b, busy_a, busy_b;

    logic [7:0]  rdatam, portm;
    logic        ackm, busym;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    int          base [2];
    logic [7:0]  port_m [2];
    logic [7:0]  snap_m [2];
    logic [7:0]  last_rd [2];
    logic [7:0]  ram_m [2][1024];
    bit          ram_ok [2][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_responder #(.RAM_AW(10), .WAIT_STATES(1), .RESET_VEC(16'h0200)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req & ~sel), .rw(rw), .addr(addr),
        .wdata(wdata), .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .port_out(port_a)
    );

    bus_responder #(.RAM_AW(10), .WAIT_STATES(0), .RESET_VEC(16'h0200)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req & sel), .rw(rw), .addr(addr),
        .wdata(wdata), .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .port_out(port_b)
    );

    assign rdatam = sel ? rdata_b : rdata_a;
    assign portm  = sel ? port_b  : port_a;
    assign ackm   = sel ? ack_b   : ack_a;
    assign busym  = sel ? busy_b  : busy_a;

    function automatic int ws(input int s);
        return (s == 1) ? 0 : 1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            base[s]    = cyc;
            port_m[s]  = 8'h00;
            snap_m[s]  = 8'h00;
            last_rd[s] = 8'h00;
        end
    endtask

    task automatic do_cycle(input int s, input bit r, input logic [15:0] a, input logic [7:0] d);
        int          lat;
        int          e;
        logic [15:0] tv;
        logic [7:0]  exp_v;
        @(negedge clk);
        sel = s[0]; req = 1'b1; rw = r; addr = a; wdata = d;
        @(negedge clk);
        rw = ~r; addr = 16'($urandom); wdata = 8'($urandom);
        checks++;
        if (busym !== 1'b1) begin
            errors++; $display("FAIL busy_after_capture addr=%h got=%b want=1", a, busym);
        end
        lat = 1;
        while (ackm !== 1'b1 && lat < 20) begin
            @(negedge clk); lat++;
        end
        checks++;
        if (lat != ws(s) + 1) begin
            errors++; $display("FAIL ack_latency dut=%0d addr=%h got=%0d want=%0d", s, a, lat, ws(s) + 1);
        end
        if (ackm === 1'b1) begin
            e  = cyc;
            tv = 16'(e - 1 - base[s]);
            if (a == 16'hFF00)                       exp_v = port_m[s];
            else if (a == 16'hFF01)                  exp_v = tv[7:0];
            else if (a == 16'hFF02)                  exp_v = snap_m[s];
            else if (a == 16'hFFFC)                  exp_v = 8'h00;
            else if (a == 16'hFFFD)                  exp_v = 8'h02;
            else if (a < 16'd1024)                   exp_v = ram_m[s][a[9:0]];
            else                                     exp_v = 8'hFF;
            checks++;
            if (r) begin
                if (rdatam !== exp_v) begin
                    errors++; $display("FAIL read_data dut=%0d addr=%h got=%h want=%h", s, a, rdatam, exp_v);
                end
                last_rd[s] = exp_v;
                if (a == 16'hFF01) snap_m[s] = tv[15:8];
            end else begin
                if (rdatam !== last_rd[s]) begin
                    errors++; $display("FAIL rdata_hold_on_write dut=%0d addr=%h got=%h want=%h", s, a, rdatam, last_rd[s]);
                end
            end
            req = 1'b0;
            @(negedge clk);
            checks++;
            if (ackm !== 1'b0) begin
                errors++; $display("FAIL ack_one_cycle dut=%0d addr=%h got=%b want=0", s, a, ackm);
            end
            if (!r) begin
                if (a == 16'hFF00) port_m[s] = d;
                if (a == 16'hFF01) base[s] = e + 1;
                if (a < 16'd1024) begin
                    ram_m[s][a[9:0]] = d; ram_ok[s][a[9:0]] = 1'b1;
                end
            end
            checks++;
            if (portm !== port_m[s]) begin
                errors++; $display("FAIL port_out dut=%0d got=%h want=%h", s, portm, port_m[s]);
            end
        end else begin
            req = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            checks++;
            if (rdatam !== 8'h00 || portm !== 8'h00 || ackm !== 1'b0 || busym !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got rdata=%h port=%h ack=%b busy=%b want 00 00 0 0",
                         s, rdatam, portm, ackm, busym);
            end
        end
        do_cycle(0, 1'b1, 16'hFF01, 8'h00);
    endtask

    task automatic test_ram_roundtrip();
        do_cycle(0, 1'b0, 16'h0123, 8'h5A);
        do_cycle(0, 1'b1, 16'h0123, 8'h00);
    endtask

    task automatic test_port_vector();
        do_cycle(0, 1'b0, 16'hFF00, 8'h3C);
        do_cycle(0, 1'b1, 16'hFFFC, 8'h00);
        do_cycle(0, 1'b1, 16'hFFFD, 8'h00);
        do_cycle(0, 1'b1, 16'h8000, 8'h00);
        do_cycle(0, 1'b1, 16'hFF00, 8'h00);
        do_cycle(0, 1'b0, 16'hFFFC, 8'h99);
        do_cycle(0, 1'b1, 16'hFFFC, 8'h00);
    endtask

    task automatic test_timer();
        while (cyc - base[0] < 16'h02FA) @(negedge clk);
        do_cycle(0, 1'b1, 16'hFF01, 8'h00);
        do_cycle(0, 1'b1, 16'hFF02, 8'h00);
        do_cycle(0, 1'b0, 16'hFF01, 8'hA5);
        do_cycle(0, 1'b1, 16'hFF01, 8'h00);
        do_cycle(0, 1'b1, 16'hFF02, 8'h00);
    endtask

    task automatic test_reset_mid_cycle();
        do_cycle(0, 1'b0, 16'h0010, 8'h11);
        @(negedge clk);
        sel = 1'b0; req = 1'b1; rw = 1'b0; addr = 16'h0010; wdata = 8'h77;
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ackm !== 1'b0) begin
                errors++; $display("FAIL ack_during_reset cycle=%0d got=%b want=0", i, ackm);
            end
        end
        rst_n = 1'b1;
        model_reset();
        do_cycle(0, 1'b1, 16'h0010, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [15:0] aa [3];
        int          t_prev;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            aa[i] = 16'(16'h0200 + i * 37);
            do_cycle(1, 1'b0, aa[i], 8'($urandom));
        end
        @(negedge clk);
        sel = 1'b1; req = 1'b1; rw = 1'b1; addr = aa[0];
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lat = 0;
            while (ackm !== 1'b1 && lat < 10) begin
                @(negedge clk); lat++;
            end
            checks++;
            if (ackm !== 1'b1) begin
                errors++; $display("FAIL b2b_ack_timeout k=%0d got=%b want=1", k, ackm);
            end else begin
                if (k > 0 && cyc - t_prev != 2) begin
                    errors++; $display("FAIL b2b_spacing k=%0d got=%0d want=2", k, cyc - t_prev);
                end
                t_prev = cyc;
                checks++;
                if (rdatam !== ram_m[1][aa[k][9:0]]) begin
                    errors++; $display("FAIL b2b_rdata k=%0d got=%h want=%h", k, rdatam, ram_m[1][aa[k][9:0]]);
                end
                last_rd[1] = ram_m[1][aa[k][9:0]];
            end
            if (k < 2) addr = aa[k+1];
            else req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int          s;
        int          kind;
        logic [15:0] a;
        for (int i = 0; i < 30; i++) begin
            s    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            a    = 16'($urandom_range(0, 1023));
            case (kind)
                0: do_cycle(s, 1'b0, a, 8'($urandom));
                1: begin
                    if (ram_ok[s][a[9:0]]) do_cycle(s, 1'b1, a, 8'h00);
                    else                   do_cycle(s, 1'b0, a, 8'($urandom));
                end
                2: do_cycle(s, 1'b1, 16'($urandom_range(16'h0400, 16'hFEFF)), 8'h00);
                default: do_cycle(s, 1'b0, 16'hFF00, 8'($urandom));
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ram_roundtrip();
        test_port_vector();
        test_timer();
        test_reset_mid_cycle();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
